// File: rtl/accum_ctrl.sv
// accum_ctrl: job sequencer for one windowed accumulator unit.
// Latches a job configuration, fires a one-cycle run into the unit, mirrors
// the unit's window counter to find each window end, and captures the window
// sum onto a valid/ready result port.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, abort                   job control pulses
//   cfg_duty, cfg_delay0, cfg_nwin job configuration (latched on start)
//   acc_run, acc_running           unit control
//   acc_duty, acc_delay0           latched unit configuration
//   acc_out                        unit window sum
//   res_data, res_valid, res_ready result port
//   busy, done, err_cfg, overflow  status
//   win_cnt                        windows completed in current job
module accum_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CFG_W  = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CFG_W-1:0]  cfg_duty,
  input  logic [CFG_W-1:0]  cfg_delay0,
  input  logic [CNT_W-1:0]  cfg_nwin,
  output logic              acc_run,
  output logic              acc_running,
  output logic [CFG_W-1:0]  acc_duty,
  output logic [CFG_W-1:0]  acc_delay0,
  input  logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              overflow,
  output logic [CNT_W-1:0]  win_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   mirror_q, mirror_d;
  logic               working_q, working_d;
  logic [CNT_W-1:0]   nwin_q, nwin_d;
  logic [CFG_W-1:0]   duty_d, delay0_d;
  logic [DATA_W-1:0]  res_data_d;
  logic               res_valid_d;
  logic               err_cfg_d;
  logic               overflow_d;
  logic [CNT_W-1:0]   win_cnt_d;
  logic               win_end;
  logic               busy_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    mirror_d    = mirror_q;
    working_d   = working_q;
    nwin_d      = nwin_q;
    duty_d      = acc_duty;
    delay0_d    = acc_delay0;
    res_data_d  = res_data;
    res_valid_d = res_valid;
    err_cfg_d   = err_cfg;
    overflow_d  = overflow;
    win_cnt_d   = win_cnt;
    win_end     = 1'b0;

    // Mirror of the unit's delay/window counter; the unit reloads on run.
    if (state_q == ARM) begin
      mirror_d  = acc_delay0;
      working_d = 1'b0;
    end else if (mirror_q != '0) begin
      mirror_d = mirror_q - CFG_W'(1);
    end else begin
      mirror_d  = acc_duty;
      working_d = 1'b1;
    end

    // Accepted result retires unless a new window end replaces it below.
    if (res_valid && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_duty != '0) begin
            duty_d      = cfg_duty;
            delay0_d    = cfg_delay0;
            nwin_d      = cfg_nwin;
            win_cnt_d   = '0;
            overflow_d  = 1'b0;
            err_cfg_d   = 1'b0;
            res_valid_d = 1'b0;
            state_d     = ARM;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ARM: begin
        state_d = abort ? IDLE : RUN;
        if (abort) res_valid_d = 1'b0;
      end
      RUN: begin
        if (abort) begin
          // Abort wins over a coincident window end.
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end else begin
          win_end = (mirror_q == '0) && working_q;
          if (win_end) begin
            if (!res_valid || res_ready) begin
              res_data_d  = acc_out;
              res_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            win_cnt_d = win_cnt + CNT_W'(1);
            if ((nwin_q != '0) && (win_cnt_d == nwin_q)) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARM) || (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mirror_q    <= '0;
      working_q   <= 1'b0;
      nwin_q      <= '0;
      acc_run     <= 1'b0;
      acc_running <= 1'b0;
      acc_duty    <= '0;
      acc_delay0  <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      overflow    <= 1'b0;
      win_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      mirror_q    <= mirror_d;
      working_q   <= working_d;
      nwin_q      <= nwin_d;
      acc_run     <= (state_d == ARM);
      acc_running <= busy_d;
      acc_duty    <= duty_d;
      acc_delay0  <= delay0_d;
      res_data    <= res_data_d;
      res_valid   <= res_valid_d;
      busy        <= busy_d;
      done        <= (state_d == DONE);
      err_cfg     <= err_cfg_d;
      overflow    <= overflow_d;
      win_cnt     <= win_cnt_d;
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Testbench for accum_ctrl with a behavioural model of the accumulator unit.
module tb_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [6:0]  cfg_duty, cfg_delay0;
  logic [15:0] cfg_nwin;
  logic        acc_run, acc_running;
  logic [6:0]  acc_duty, acc_delay0;
  logic [31:0] acc_out;
  logic [31:0] res_data;
  logic        res_valid, res_ready;
  logic        busy, done, err_cfg, overflow;
  logic [15:0] win_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  accum_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_duty(cfg_duty), .cfg_delay0(cfg_delay0), .cfg_nwin(cfg_nwin),
    .acc_run(acc_run), .acc_running(acc_running),
    .acc_duty(acc_duty), .acc_delay0(acc_delay0), .acc_out(acc_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .err_cfg(err_cfg), .overflow(overflow),
    .win_cnt(win_cnt)
  );

  // Unit model: delay0 countdown, then windows of duty samples of in0.
  logic [31:0] in0;
  logic [6:0]  ucnt = '0;
  logic        uwork = 1'b0;
  logic [31:0] uacc = '0;
  assign acc_out = uacc;

  always @(posedge clk) begin
    if (acc_run) begin
      ucnt  <= acc_delay0;
      uwork <= 1'b0;
      uacc  <= '0;
    end else if (ucnt != 7'd0) begin
      ucnt <= ucnt - 7'd1;
      if (uwork) uacc <= uacc + in0;
    end else begin
      ucnt  <= acc_duty;
      uwork <= 1'b1;
      uacc  <= '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to a fresh cycle and pulse start in it.
  task automatic start_job(input logic [6:0] d, input logic [6:0] d0, input logic [15:0] n);
    tick();
    cfg_duty   = d;
    cfg_delay0 = d0;
    cfg_nwin   = n;
    start      = 1'b1;
  endtask

  // Expected outputs for cycles 1..17 of delay0=3, duty=4, nwin=2, in0=1.
  typedef struct {
    logic        start_in;
    logic        ready_in;
    logic        run;
    logic        valid;
    logic        done;
    logic        busy;
    logic [31:0] data;
    logic [15:0] wc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic run_table(input int extra_start_cyc);
    in0 = 32'd1;
    res_ready = 1'b1;
    start_job(7'd4, 7'd3, 16'd2);
    for (int i = 0; i < NV; i++) begin
      int c;
      c = i + 1;
      tick();
      start     = vecs[i].start_in || (c == extra_start_cyc);
      res_ready = vecs[i].ready_in;
      // An ignored start also carries a different duty that must not latch.
      if (c == extra_start_cyc) cfg_duty = 7'd2;
      check($sformatf("c%0d acc_run", c),   64'(acc_run),   64'(vecs[i].run));
      check($sformatf("c%0d res_valid", c), 64'(res_valid), 64'(vecs[i].valid));
      check($sformatf("c%0d done", c),      64'(done),      64'(vecs[i].done));
      check($sformatf("c%0d busy", c),      64'(busy),      64'(vecs[i].busy));
      check($sformatf("c%0d res_data", c),  64'(res_data),  64'(vecs[i].data));
      check($sformatf("c%0d win_cnt", c),   64'(win_cnt),   64'(vecs[i].wc));
    end
    start = 1'b0;
  endtask

  initial begin
    int vcount, dcount;
    logic run_seen, busy_seen;

    for (int i = 0; i < NV; i++) begin
      int c;
      c = i + 1;
      vecs[i].start_in = 1'b0;
      vecs[i].ready_in = 1'b1;
      vecs[i].run      = (c == 1);
      vecs[i].valid    = (c == 11) || (c == 16);
      vecs[i].done     = (c == 16);
      vecs[i].busy     = (c <= 15);
      vecs[i].data     = (c >= 11) ? 32'd4 : 32'd0;
      vecs[i].wc       = (c >= 16) ? 16'd2 : ((c >= 11) ? 16'd1 : 16'd0);
    end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0; in0 = 32'd1;
    cfg_duty = '0; cfg_delay0 = '0; cfg_nwin = '0;
    tick(); tick();
    check("reset ctl", 64'({acc_run, acc_running, acc_duty, acc_delay0, res_valid,
                            busy, done, err_cfg, overflow, win_cnt}), 64'd0);
    check("reset res_data", 64'(res_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic job driven from the vector table.
    run_table(-1);

    // duty == 0 is rejected.
    start_job(7'd0, 7'd2, 16'd1);
    run_seen = 1'b0; busy_seen = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      run_seen  |= acc_run;
      busy_seen |= busy;
    end
    check("dutyzero err_cfg", 64'(err_cfg), 64'd1);
    check("dutyzero acc_run", 64'(run_seen), 64'd0);
    check("dutyzero busy", 64'(busy_seen), 64'd0);

    // Back-pressure: first sum held, later ones dropped.
    in0 = 32'd1; res_ready = 1'b0;
    start_job(7'd2, 7'd0, 16'd3);
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) check("bp err_cfg cleared", 64'(err_cfg), 64'd0);
      if (c == 6) begin
        check("bp c6 valid", 64'(res_valid), 64'd1);
        check("bp c6 data", 64'(res_data), 64'd2);
        check("bp c6 win_cnt", 64'(win_cnt), 64'd1);
        in0 = 32'd3;
      end
      if (c == 8) check("bp c8 overflow", 64'(overflow), 64'd0);
      if (c == 9) begin
        check("bp c9 overflow", 64'(overflow), 64'd1);
        check("bp c9 data", 64'(res_data), 64'd2);
        check("bp c9 win_cnt", 64'(win_cnt), 64'd2);
      end
      if (c == 12) begin
        check("bp c12 done", 64'(done), 64'd1);
        check("bp c12 data", 64'(res_data), 64'd2);
        check("bp c12 win_cnt", 64'(win_cnt), 64'd3);
        check("bp c12 valid", 64'(res_valid), 64'd1);
      end
      if (c == 13) begin
        check("bp c13 done", 64'(done), 64'd0);
        check("bp c13 busy", 64'(busy), 64'd0);
        check("bp c13 valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
      end
      if (c == 14) check("bp c14 valid", 64'(res_valid), 64'd0);
    end

    // Free-running job stopped by abort in cycle 20.
    in0 = 32'd1; res_ready = 1'b1;
    start_job(7'd1, 7'd0, 16'd0);
    vcount = 0; dcount = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      start = 1'b0;
      abort = (c == 20);
      if (res_valid) vcount++;
      if (done) dcount++;
      if (c == 5) check("free c5 data", 64'(res_data), 64'd1);
      if (c == 20) check("free c20 busy", 64'(busy), 64'd1);
    end
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort win_cnt", 64'(win_cnt), 64'd8);
    check("abort results", 64'(vcount), 64'd8);
    check("abort no done", 64'(dcount), 64'd0);
    check("abort valid", 64'(res_valid), 64'd0);

    // Reset in the middle of a job with pending status.
    res_ready = 1'b0;
    start_job(7'd1, 7'd0, 16'd0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
    end
    check("prerst overflow", 64'(overflow), 64'd1);
    check("prerst win_cnt", 64'(win_cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    check("midrst ctl", 64'({acc_run, acc_running, acc_duty, acc_delay0, res_valid,
                             busy, done, err_cfg, overflow, win_cnt}), 64'd0);
    check("midrst res_data", 64'(res_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh job after reset, with a start pulse during RUN that must be ignored.
    run_table(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Sequencer for a single windowed accumulator unit (7-bit `duty`/`delay0`, 32-bit `out0`) in the Versat datapath. The block latches a job configuration and issues the one-cycle `run` that starts the unit. It tracks the unit's window schedule with an internal mirror counter, captures each completed window sum and presents it on a valid/ready result port. It sits between the host configuration registers and the accumulator instance.

## Interface
Parameters:
- `DATA_W`, 32, accumulator data width
- `CFG_W`, 7, width of `duty`/`delay0`
- `CNT_W`, 16, window counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle job start pulse
- `abort`  in  1  one-cycle job abort pulse
- `cfg_duty`  in  CFG_W  window length in accumulated samples
- `cfg_delay0`  in  CFG_W  initial delay before first window
- `cfg_nwin`  in  CNT_W  windows per job; 0 = free-running until abort
- `acc_run`  out  1  to unit `run`
- `acc_running`  out  1  to unit `running`
- `acc_duty`  out  CFG_W  to unit `duty` (latched)
- `acc_delay0`  out  CFG_W  to unit `delay0` (latched)
- `acc_out`  in  DATA_W  from unit `out0`
- `res_data`  out  DATA_W  captured window sum
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `busy`  out  1  job in progress (ARM or RUN)
- `done`  out  1  one-cycle pulse at job completion
- `err_cfg`  out  1  sticky: start rejected (`cfg_duty` == 0)
- `overflow`  out  1  sticky: window sum dropped
- `win_cnt`  out  CNT_W  windows captured in current job

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE, `start`=1, `cfg_duty`!=0: latch `cfg_*`; clear `win_cnt`, `overflow`, `err_cfg`, `res_valid`; go to ARM.
- IDLE, `start`=1, `cfg_duty`==0: set `err_cfg`, stay in IDLE.
- `start` outside IDLE is ignored.
- ARM: `acc_run`=1 for exactly this cycle. The mirror counter loads `acc_delay0` and mirror `working` is cleared. Go to RUN.
- Mirror counter follows the unit exactly:
  - nonzero: decrement;
  - zero: load `acc_duty`, set `working`=1.
- Window end: RUN, mirror==0, `working`=1. `acc_out` then holds the sum of the preceding `duty` samples.
- At window end:
  - if `res_valid`=0 or `res_ready`=1: `res_data`<=`acc_out`, `res_valid`<=1, `win_cnt`++;
  - else: drop the sum, set `overflow`, `win_cnt`++ (counts windows, not deliveries).
- Handshake: the result is accepted when `res_valid`&`res_ready`. With no window end in the same cycle, `res_valid`<=0.
- When `cfg_nwin`!=0 and the increment makes `win_cnt`==`cfg_nwin`: go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `res_valid`/`res_data` persist until accepted.
- `abort` in ARM/RUN: go to IDLE next cycle; `res_valid` cleared; no `done`. `abort` has priority over a same-cycle window end.
- `acc_running` = `busy` = state is ARM or RUN.
- `win_cnt` wraps modulo 2^CNT_W in free-running mode.

## Timing
- Reset values: all outputs 0; state IDLE; mirror counter 0.
- `start` in cycle T: ARM in T+1 (`acc_run` high in T+1), RUN from T+2.
- First window end in cycle T+3+delay0+duty. `res_valid` rises in T+4+delay0+duty.
- Subsequent window ends every duty+1 cycles.
- Last window end in cycle E: `done` high in E+1, IDLE in E+2; `start` accepted from E+2.
- `delay0`=0: first window end in T+3+duty.
- `rst_n` low mid-job: immediate return to IDLE, all outputs 0, no `done`.

## Test plan
- `delay0`=3, `duty`=4, `nwin`=2, `acc_out` driven from a behavioural unit model fed `in0`=1, `res_ready`=1, `start` at T=0:
  - `acc_run` only in cycle 1;
  - `res_data`=4 valid in cycles 11 and 16;
  - `done` in cycle 16; `win_cnt`=2.
- `duty`=0 `start` -> `err_cfg`=1, `acc_run` never asserted, `busy`=0.
- `duty`=2, `nwin`=3, `res_ready`=0 -> first sum held; `overflow`=1 after the second window end; `done` after the third; `res_data` still the first sum.
- `nwin`=0, `duty`=1, `abort` at cycle 20 -> results every 2 cycles until abort; `busy`=0 at cycle 21; no `done`.
- `rst_n` low during RUN -> all outputs 0 the same cycle; a fresh `start` behaves as in the first scenario.
- `start` pulsed again during RUN -> ignored; schedule and `win_cnt` unchanged.
